store_buffer: RTL

//   Write-side counterpart of the MEM-stage load path: accepts store requests from the pipeline,

---
 rtl/store_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer: formats pipeline stores (byte-lane alignment and byte enables),
// queues them in a small FIFO and drains them to data memory over req/ack.
// The head entry stays counted in the FIFO until memory acknowledges it.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [AW-1:0] st_addr,
   input  logic [31:0]   st_data,
   input  logic [2:0]    dm_ctrl,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_be,
   input  logic          mem_ack,
   output logic          misalign,
   output logic          empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Shared data-memory access-width encodings
   localparam logic [2:0] dm_byte              = 3'b000;
   localparam logic [2:0] dm_halfword          = 3'b001;
   localparam logic [2:0] dm_word              = 3'b010;
   localparam logic [2:0] dm_byte_unsigned     = 3'b100;
   localparam logic [2:0] dm_halfword_unsigned = 3'b101;

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t        state;
   logic [AW-3:0] q_addr  [DEPTH];
   logic [31:0]   q_wdata [DEPTH];
   logic [3:0]    q_be    [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_nxt;
   logic [PW:0]   count;
   logic [PW:0]   cnt_rem;

   logic          legal;
   logic [3:0]    fmt_be;
   logic [31:0]   fmt_wdata;
   logic          push_acc;
   logic          push;
   logic          pop;
   logic          load;

   // Lane alignment, byte enables and legality of the incoming store
   always_comb begin
      legal     = 1'b0;
      fmt_be    = '0;
      fmt_wdata = st_data;
      unique case (dm_ctrl)
         dm_byte, dm_byte_unsigned: begin
            legal     = 1'b1;
            fmt_be    = 4'b0001 << st_addr[1:0];
            fmt_wdata = {4{st_data[7:0]}};
         end
         dm_halfword, dm_halfword_unsigned: begin
            legal     = ~st_addr[0];
            fmt_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            fmt_wdata = {2{st_data[15:0]}};
         end
         dm_word: begin
            legal     = (st_addr[1:0] == 2'b00);
            fmt_be    = 4'b1111;
            fmt_wdata = st_data;
         end
         default: begin
            legal     = 1'b0;
         end
      endcase
   end

   assign st_ready = (count != (PW+1)'(DEPTH));
   assign push_acc = st_valid && st_ready;
   assign push     = push_acc && legal;
   assign pop      = (state == S_REQ) && mem_ack;
   assign cnt_rem  = count - (PW+1)'(pop);
   assign rd_nxt   = rd_ptr + PW'(pop);
   // A new head is presented whenever the port is free (idle, or the current
   // head is being acked) and something is either queued behind it or arriving.
   assign load     = ((state == S_IDLE) || pop) && ((cnt_rem != '0) || push);
   assign mem_req  = (state == S_REQ);
   assign empty    = (count == '0) && (state == S_IDLE);

   // FIFO storage write
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr]  <= st_addr[AW-1:2];
         q_wdata[wr_ptr] <= fmt_wdata;
         q_be[wr_ptr]    <= fmt_be;
      end
   end

   // Pointers, occupancy and the one-cycle misalign pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         misalign <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr   <= rd_nxt;
         count    <= cnt_rem + (PW+1)'(push);
         misalign <= push_acc && !legal;
      end
   end

   // Drain FSM with registered memory-side outputs; when nothing is left the
   // head comes straight from the incoming store so idle latency is one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else if (load) begin
         state <= S_REQ;
         if (cnt_rem != '0) begin
            mem_addr  <= {q_addr[rd_nxt], 2'b00};
            mem_wdata <= q_wdata[rd_nxt];
            mem_be    <= q_be[rd_nxt];
         end else begin
            mem_addr  <= {st_addr[AW-1:2], 2'b00};
            mem_wdata <= fmt_wdata;
            mem_be    <= fmt_be;
         end
      end else if (pop) begin
         state <= S_IDLE;
      end
   end

endmodule
